// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forwarding controller with memory-wait timeout and saturating stats
module hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       srcAddD1,
  input  logic [3:0]       srcAddD2,
  input  logic             useSrcD1,
  input  logic             useSrcD2,
  input  logic [3:0]       destAddE,
  input  logic             RegWriteE,
  input  logic             MemToRegE,
  input  logic [3:0]       srcAddE1,
  input  logic [3:0]       srcAddE2,
  input  logic [3:0]       destAddM,
  input  logic             RegWriteM,
  input  logic [3:0]       destAddW,
  input  logic             RegWriteW,
  input  logic             branchTakenE,
  input  logic             memReqM,
  input  logic             memReadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushC,
  output logic [1:0]       fwdSelE1,
  output logic [1:0]       fwdSelE2,
  output logic             memErr,
  output logic             halt,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic mem_busy, load_use, at_max;
  assign mem_busy = memReqM & ~memReadyM;
  assign load_use = RegWriteE & MemToRegE & (destAddE != 4'd0) &
                    ((useSrcD1 & (srcAddD1 == destAddE)) | (useSrcD2 & (srcAddD2 == destAddE)));
  assign at_max   = wait_q == 8'(MAX_WAIT);
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = 1'b0;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushD    = 1'b0;
    flushC    = 1'b0;
    halt      = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          {stallF, stallD, stallE} = 3'b111;
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end else if (branchTakenE) begin
          {flushD, flushC} = 2'b11;
        end else if (load_use) begin
          {stallF, stallD, flushC} = 3'b111;
        end
      end
      MEM_WAIT: begin
        if (memReadyM) begin
          state_d = RUN;
        end else begin
          {stallF, stallD, stallE} = 3'b111;
          if (at_max) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      default: begin
        {stallF, stallD, stallE} = 3'b111;
        halt = 1'b1;
      end
    endcase
    fwdSelE1 = (srcAddE1 == 4'd0) ? 2'b00 :
               (RegWriteM && destAddM == srcAddE1) ? 2'b10 :
               (RegWriteW && destAddW == srcAddE1) ? 2'b01 : 2'b00;
    fwdSelE2 = (srcAddE2 == 4'd0) ? 2'b00 :
               (RegWriteM && destAddM == srcAddE2) ? 2'b10 :
               (RegWriteW && destAddW == srcAddE2) ? 2'b01 : 2'b00;
    // while reset is held the pipeline is flushed and nothing is stalled or forwarded
    if (!reset) begin
      {stallF, stallD, stallE, halt} = 4'b0000;
      {flushD, flushC} = 2'b11;
      fwdSelE1 = 2'b00;
      fwdSelE2 = 2'b00;
    end
    stall_cnt_d = (stallD && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flushC && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_q      <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign memErr   = mem_err_q;
  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus randomized check of hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;
  localparam int MW   = 4;
  localparam int CMAX = 15;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] srcAddD1, srcAddD2, destAddE, srcAddE1, srcAddE2, destAddM, destAddW;
  logic useSrcD1, useSrcD2, RegWriteE, MemToRegE, RegWriteM, RegWriteW;
  logic branchTakenE, memReqM, memReadyM;
  logic stallF, stallD, stallE, flushD, flushC, memErr, halt;
  logic [1:0] fwdSelE1, fwdSelE2;
  logic [3:0] stallCnt, flushCnt;
  int n_vec = 0;
  int n_bad = 0;
  int m_frozen = 0;
  bit m_halt = 0;
  bit m_err = 0;
  int m_scnt = 0;
  int m_fcnt = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .srcAddD1(srcAddD1), .srcAddD2(srcAddD2), .useSrcD1(useSrcD1), .useSrcD2(useSrcD2),
    .destAddE(destAddE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
    .srcAddE1(srcAddE1), .srcAddE2(srcAddE2),
    .destAddM(destAddM), .RegWriteM(RegWriteM), .destAddW(destAddW), .RegWriteW(RegWriteW),
    .branchTakenE(branchTakenE), .memReqM(memReqM), .memReadyM(memReadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushC(flushC),
    .fwdSelE1(fwdSelE1), .fwdSelE2(fwdSelE2), .memErr(memErr), .halt(halt),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  function automatic logic [1:0] fwd_ref(input logic [3:0] s);
    if (s == 4'd0) return 2'b00;
    if (RegWriteM && destAddM == s) return 2'b10;
    if (RegWriteW && destAddW == s) return 2'b01;
    return 2'b00;
  endfunction
  task automatic idle();
    reset = 1'b1;
    {srcAddD1, srcAddD2, destAddE, srcAddE1, srcAddE2, destAddM, destAddW} = '0;
    {useSrcD1, useSrcD2, RegWriteE, MemToRegE, RegWriteM, RegWriteW} = '0;
    {branchTakenE, memReqM, memReadyM} = '0;
  endtask
  task automatic set_load_use();
    RegWriteE = 1'b1; MemToRegE = 1'b1; destAddE = 4'd3; useSrcD1 = 1'b1; srcAddD1 = 4'd3;
  endtask
  // one cycle: compare outputs against the model for the driven inputs, then advance the model
  task automatic step();
    bit lu, busy, in_wait;
    bit e_sf, e_sd, e_se, e_fd, e_fc, e_halt;
    logic [1:0] e_f1, e_f2;
    #1;
    in_wait = m_frozen > 0;
    busy = memReqM && !memReadyM;
    lu = RegWriteE && MemToRegE && destAddE != 0 &&
         ((useSrcD1 && srcAddD1 == destAddE) || (useSrcD2 && srcAddD2 == destAddE));
    {e_sf, e_sd, e_se, e_fd, e_fc, e_halt} = '0;
    e_f1 = fwd_ref(srcAddE1);
    e_f2 = fwd_ref(srcAddE2);
    if (!reset) begin
      {e_fd, e_fc} = 2'b11;
      e_f1 = 2'b00;
      e_f2 = 2'b00;
    end else if (m_halt) begin
      {e_sf, e_sd, e_se, e_halt} = 4'b1111;
    end else if (in_wait) begin
      {e_sf, e_sd, e_se} = {3{!memReadyM}};
    end else if (busy) begin
      {e_sf, e_sd, e_se} = 3'b111;
    end else if (branchTakenE) begin
      {e_fd, e_fc} = 2'b11;
    end else if (lu) begin
      {e_sf, e_sd, e_fc} = 3'b111;
    end
    chk("stallF", stallF, e_sf);
    chk("stallD", stallD, e_sd);
    chk("stallE", stallE, e_se);
    chk("flushD", flushD, e_fd);
    chk("flushC", flushC, e_fc);
    chk("halt", halt, e_halt);
    chk("fwdSelE1", fwdSelE1, e_f1);
    chk("fwdSelE2", fwdSelE2, e_f2);
    chk("memErr", memErr, m_err);
    chk("stallCnt", stallCnt, m_scnt);
    chk("flushCnt", flushCnt, m_fcnt);
    m_err = 0;
    if (!reset) begin
      m_halt = 0; m_frozen = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (m_halt) begin
      end else if (in_wait) begin
        if (memReadyM) m_frozen = 0;
        else if (m_frozen == MW) begin m_halt = 1; m_frozen = 0; m_err = 1; end
        else m_frozen++;
      end else if (busy) begin
        m_frozen = 1;
      end
      m_scnt = (m_scnt + e_sd > CMAX) ? CMAX : m_scnt + e_sd;
      m_fcnt = (m_fcnt + e_fc > CMAX) ? CMAX : m_fcnt + e_fc;
    end
    @(negedge clk);
  endtask
  initial begin
    idle();
    reset = 1'b0;
    @(negedge clk);
    step();
    step();
    reset = 1'b1;
    step();
    set_load_use();
    step();
    idle();
    step();
    chk("ld_stallCnt", stallCnt, 1);
    chk("ld_flushCnt", flushCnt, 1);
    set_load_use();
    destAddE = 4'd0;
    step();
    set_load_use();
    branchTakenE = 1'b1;
    step();
    idle();
    srcAddE1 = 4'd5; destAddM = 4'd5; RegWriteM = 1'b1; destAddW = 4'd5; RegWriteW = 1'b1;
    step();
    RegWriteM = 1'b0;
    step();
    srcAddE1 = 4'd0;
    step();
    idle();
    memReqM = 1'b1;
    repeat (3) step();
    memReadyM = 1'b1;
    step();
    idle();
    step();
    chk("wait_memErr", memErr, 0);
    memReqM = 1'b1;
    repeat (MW + 1) step();
    chk("to_memErr", memErr, 1);
    chk("to_halt", halt, 1);
    step();
    chk("to_memErr_drop", memErr, 0);
    chk("to_halt_hold", halt, 1);
    reset = 1'b0;
    step();
    idle();
    chk("rst_halt", halt, 0);
    chk("rst_stallCnt", stallCnt, 0);
    set_load_use();
    repeat (20) step();
    idle();
    chk("sat_stallCnt", stallCnt, 15);
    step();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 60) != 0);
      srcAddD1 = 4'($urandom_range(0, 3));
      srcAddD2 = 4'($urandom_range(0, 3));
      useSrcD1 = 1'($urandom);
      useSrcD2 = 1'($urandom);
      destAddE = 4'($urandom_range(0, 3));
      RegWriteE = 1'($urandom);
      MemToRegE = 1'($urandom);
      srcAddE1 = 4'($urandom_range(0, 3));
      srcAddE2 = 4'($urandom_range(0, 3));
      destAddM = 4'($urandom_range(0, 3));
      RegWriteM = 1'($urandom);
      destAddW = 4'($urandom_range(0, 3));
      RegWriteW = 1'($urandom);
      branchTakenE = ($urandom_range(0, 3) == 0);
      memReqM = ($urandom_range(0, 4) == 0);
      memReadyM = ($urandom_range(0, 2) == 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
